// File: rtl/ir_output_writer.sv
// ir_output_writer
// ----------------
// Output stage behind inverted_residual_block. Takes the block's 16-bit result
// stream, packs pairs of elements into 32-bit words, and holds them in a small
// FIFO. It then writes them to main memory at consecutive word addresses. done
// is raised once the programmed number of elements has been committed.
//
// Optional feature: define IR_OUT_RELU6_EN to clamp every accepted element to
// [0, 6<<FRAC] before packing. The clamp is combinational and adds no latency.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset (aborts any transfer)
//   start      one-cycle pulse; latches base_addr / n_elems (IDLE or DONE only)
//   base_addr  first memory word address
//   n_elems    number of DW-bit elements to write
//   in_valid   element valid (upstream w_valid)
//   in_data    element (upstream ram_val)
//   mem_req    write request, high while the FIFO holds a word
//   mem_addr   word address of the FIFO head
//   mem_wdata  FIFO head word: element 2k in [DW-1:0], 2k+1 in [2DW-1:DW]
//   mem_gnt    memory accepts the current request this cycle
//   busy       high in RUN and FLUSH
//   done       level, high in DONE
//   ovf        sticky; a completed word was dropped on a full FIFO
//
// Memory handshake: a word transfers on a rising edge where mem_req && mem_gnt.
// While mem_req is high and mem_gnt low, mem_req, mem_addr and mem_wdata hold
// their values. mem_gnt is ignored while mem_req is low.

module ir_output_writer #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 16,
  parameter int FRAC  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [CW-1:0]   n_elems,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [2*DW-1:0] mem_wdata,
  input  logic            mem_gnt,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);

`ifdef IR_OUT_RELU6_EN
  localparam bit RELU6_EN = 1'b1;
`else
  localparam bit RELU6_EN = 1'b0;
`endif

  localparam logic [DW-1:0] RELU6_MAX = DW'(6) << FRAC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Transfer context
  logic [AW-1:0] base_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] idx_q;     // index of the next element to accept
  logic [DW-1:0] lo_q;      // even element waiting for its partner
  logic          ovf_q;

  // Word FIFO: each entry carries its own address, so a dropped word leaves a
  // gap in the address sequence and later words stay aligned to their index.
  logic [2*DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   fifo_addr [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count_q;

  logic            fifo_empty, fifo_full;
  logic            accept, last_elem;
  logic            push, push_ok, pop, drop;
  logic            start_ok;
  logic [DW-1:0]   elem;
  logic [2*DW-1:0] push_word;
  logic [AW-1:0]   push_addr;

  // Element conditioning (optional ReLU6 clamp, purely combinational)
  always_comb begin
    elem = in_data;
    if (RELU6_EN) begin
      if (in_data[DW-1]) begin
        elem = '0;
      end else if (in_data > RELU6_MAX) begin
        elem = RELU6_MAX;
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  assign accept    = (state_q == S_RUN) && in_valid;
  assign last_elem = (idx_q == (n_q - IDX_ONE));
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // An odd index completes a pair; an even last element goes out alone with
  // the high half zero-filled.
  assign push      = accept && (idx_q[0] || last_elem);
  assign push_word = idx_q[0] ? {elem, lo_q} : {{DW{1'b0}}, elem};
  assign push_addr = base_q + AW'(idx_q >> 1);

  assign pop     = mem_req && mem_gnt;
  // A full FIFO still takes the word when the head retires on the same edge.
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  assign mem_req   = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : fifo_addr[rd_ptr];
  assign mem_wdata = fifo_empty ? '0 : fifo_data[rd_ptr];

  assign busy = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done = (state_q == S_DONE);
  assign ovf  = ovf_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (n_elems == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && last_elem) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // No pushes happen here, so the grant of the only remaining entry is
        // the grant of the final word.
        if (fifo_empty || (pop && (count_q == CNT_ONE))) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and transfer context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q <= base_addr;
        n_q    <= n_elems;
        idx_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (accept) begin
        idx_q <= idx_q + IDX_ONE;
        if (!idx_q[0]) begin
          lo_q <= elem;
        end
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage. It is not reset because the outputs are masked while the
  // FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= push_word;
      fifo_addr[wr_ptr] <= push_addr;
    end
  end

endmodule
